// File: rtl/uart_pkg.sv
// Shared UART definitions for the serialiser and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MaxDataW = 32;

  // Callers zero-extend narrower codewords; padding does not change the XOR.
  function automatic logic parity_bit(input logic [MaxDataW-1:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick_o is high on the last clock of each line bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART serialiser with a one-entry holding register for gapless frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 15,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic              clk_tx,
  input  logic              rst_n_tx,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic [1:0]        parity_mode,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [1:0]        hold_par_q, hold_par_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic              loaded_q, loaded_d;
  logic              tx_out_q, tx_out_d;

  logic                tick, restart, hs, take_hold, par_en;
  logic [DATA_W-1:0]   data_ord;
  logic [MaxDataW-1:0] par_data;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk_tx),
    .rst_ni   (rst_n_tx),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_out   = tx_out_q;
  assign hs       = tx_valid & ~hold_full_q;
  assign par_en   = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
  // Held at zero while idle, and zeroed on every state change.
  assign restart  = (state_q == StIdle) || (state_d != state_q);

  // Reorder so transmit order always walks index 0 upwards.
  always_comb begin
    for (int i = 0; i < int'(DATA_W); i++) begin
      data_ord[i] = MSB_FIRST ? shift_q[DATA_W-1-i] : shift_q[i];
    end
    par_data = '0;
    par_data[DATA_W-1:0] = shift_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_par_d  = hold_par_q;
    shift_d     = shift_q;
    par_mode_d  = par_mode_q;
    bit_idx_d   = bit_idx_q;
    loaded_d    = loaded_q;
    take_hold   = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (loaded_q) begin
          state_d  = StStart;
          loaded_d = 1'b0;
        end else if (hold_full_q) begin
          take_hold = 1'b1;
          loaded_d  = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == IdxW'(DATA_W - 1)) begin
            bit_idx_d = '0;
            state_d   = par_en ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_idx_q == IdxW'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            bit_idx_d  = '0;
            if (hold_full_q) begin
              take_hold = 1'b1;
              state_d   = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_hold) begin
      shift_d    = hold_data_q;
      par_mode_d = hold_par_q;
    end
    if (hs) begin
      hold_data_d = tx_data;
      hold_par_d  = parity_mode;
    end
    hold_full_d = (hold_full_q & ~take_hold) | hs;

    // Line value for the state being entered, so tx_out comes straight from a flop.
    unique case (state_d)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = data_ord[bit_idx_d];
      StParity: tx_out_d = parity_bit(par_data, par_mode_q);
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_tx or negedge rst_n_tx) begin
    if (!rst_n_tx) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_par_q  <= PAR_NONE;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_mode_q  <= PAR_NONE;
      bit_idx_q   <= '0;
      loaded_q    <= 1'b0;
      tx_out_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_par_q  <= hold_par_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_mode_q  <= par_mode_d;
      bit_idx_q   <= bit_idx_d;
      loaded_q    <= loaded_d;
      tx_out_q    <= tx_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit codewords, 4 clocks per bit, MSB first, 1 stop bit.
module tb_uart_tx_param;

  logic       clk_tx = 1'b0;
  logic       rst_n_tx = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic [1:0] parity_mode = '0;
  logic       tx_ready, tx_out, tx_busy, frame_done;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [15:0] bits;  // line bits in send order, first bit at [n-1]
    int          n;
  } vec_t;

  vec_t vecs[7];

  uart_tx_param #(
    .DATA_W      (8),
    .CLKS_PER_BIT(4),
    .STOP_BITS   (1),
    .MSB_FIRST   (1'b1)
  ) dut (
    .clk_tx     (clk_tx),
    .rst_n_tx   (rst_n_tx),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .parity_mode(parity_mode),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 clk_tx = ~clk_tx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!(tx_ready && !tx_busy) && i < 400) begin
      step();
      i++;
    end
    check("wait_idle", 32'(tx_ready && !tx_busy), 32'd1);
  endtask

  task automatic send_check(input string name, input logic [7:0] data, input logic [1:0] mode,
                            input logic [15:0] bits, input int n);
    wait_idle();
    tx_data     = data;
    parity_mode = mode;
    tx_valid    = 1'b1;
    step();
    tx_valid = 1'b0;
    check($sformatf("%s ready_after_hs", name), 32'(tx_ready), 32'd0);
    step();
    check($sformatf("%s latency_high", name), 32'(tx_out), 32'd1);
    for (int c = 1; c <= n * 4; c++) begin
      step();
      check($sformatf("%s bit c%0d", name, c), 32'(tx_out), 32'(bits[n - 1 - (c - 1) / 4]));
      check($sformatf("%s done c%0d", name, c), 32'(frame_done), 32'(c == n * 4));
      check($sformatf("%s busy c%0d", name, c), 32'(tx_busy), 32'd1);
    end
    step();
    check($sformatf("%s idle_out", name), 32'(tx_out), 32'd1);
    check($sformatf("%s idle_busy", name), 32'(tx_busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  words[3];
    logic [29:0] stream;
    int          wi;
    logic        hs;

    vecs[0] = '{data: 8'hA5, mode: 2'b00, bits: 16'b0101001011, n: 10};
    vecs[1] = '{data: 8'h07, mode: 2'b01, bits: 16'b00000011111, n: 11};
    vecs[2] = '{data: 8'h07, mode: 2'b10, bits: 16'b00000011101, n: 11};
    vecs[3] = '{data: 8'h00, mode: 2'b10, bits: 16'b00000000011, n: 11};
    vecs[4] = '{data: 8'hFF, mode: 2'b01, bits: 16'b01111111101, n: 11};
    vecs[5] = '{data: 8'h3C, mode: 2'b11, bits: 16'b0001111001, n: 10};
    vecs[6] = '{data: 8'h81, mode: 2'b01, bits: 16'b01000000101, n: 11};

    // Reset then idle
    rst_n_tx = 1'b0;
    repeat (3) @(posedge clk_tx);
    #1;
    check("in_reset tx_out", 32'(tx_out), 32'd1);
    check("in_reset ready", 32'(tx_ready), 32'd1);
    rst_n_tx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle%0d tx_out", i), 32'(tx_out), 32'd1);
      check($sformatf("idle%0d ready", i), 32'(tx_ready), 32'd1);
      check($sformatf("idle%0d busy", i), 32'(tx_busy), 32'd0);
      check($sformatf("idle%0d done", i), 32'(frame_done), 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      send_check($sformatf("vec%0d", v), vecs[v].data, vecs[v].mode, vecs[v].bits, vecs[v].n);
    end

    // Three words streamed with tx_valid held: gapless frames, third word back-pressured
    wait_idle();
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    words[2] = 8'h5A;
    stream = {10'b0001111001, 10'b0110000111, 10'b0010110101};
    wi = 0;
    tx_data = words[0];
    parity_mode = 2'b00;
    tx_valid = 1'b1;
    for (int e = 0; e <= 125; e++) begin
      hs = tx_valid && tx_ready;
      step();
      if (hs) begin
        wi++;
        if (wi < 3) tx_data = words[wi];
        else tx_valid = 1'b0;
      end
      check($sformatf("b2b e%0d ready", e), 32'(tx_ready),
            32'(e == 1 || e == 42 || e >= 82));
      check($sformatf("b2b e%0d tx_out", e), 32'(tx_out),
            (e >= 2 && e <= 121) ? 32'(stream[29 - (e - 2) / 4]) : 32'd1);
      check($sformatf("b2b e%0d done", e), 32'(frame_done),
            32'(e == 41 || e == 81 || e == 121));
      check($sformatf("b2b e%0d busy", e), 32'(tx_busy), 32'(e >= 2 && e <= 121));
    end
    check("b2b words_taken", 32'(wi), 32'd3);

    // Reset during data bit 3 of 0xFF with a second word waiting in the hold register
    wait_idle();
    tx_data = 8'hFF;
    parity_mode = 2'b00;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h81;
    step();
    step();
    tx_valid = 1'b0;
    check("rst hold_full", 32'(tx_ready), 32'd0);
    repeat (17) step();
    check("rst pre busy", 32'(tx_busy), 32'd1);
    #3;
    rst_n_tx = 1'b0;
    #1;
    check("rst async tx_out", 32'(tx_out), 32'd1);
    check("rst async busy", 32'(tx_busy), 32'd0);
    check("rst async ready", 32'(tx_ready), 32'd1);
    repeat (2) @(posedge clk_tx);
    #1;
    rst_n_tx = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      check($sformatf("post_rst%0d tx_out", i), 32'(tx_out), 32'd1);
      check($sformatf("post_rst%0d busy", i), 32'(tx_busy), 32'd0);
    end
    send_check("after_rst", 8'h5A, 2'b01, 16'b00101101001, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
